// File: rtl/zigzag_dequantizer_pp.sv
// Zig-zag ordered coefficient dequantizer: power-of-two scaling with saturation,
// written into a ping-pong pair of 8x8 block banks released by the IDCT side.
module zigzag_dequantizer_pp #(
  parameter int IN_WIDTH   = 9,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic [1:0]            quant_sel,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [OUT_WIDTH-1:0]  wr_data,
  output logic                  block_done,
  input  logic                  bank_release,
  output logic [1:0]            bank_full,
  output logic                  overflow
);

  // Handshake: a coefficient transfers on a clock edge where in_valid & in_ready;
  // in_ready depends only on the fill state of the bank being written.

  localparam int EXT_W = OUT_WIDTH + 6;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [5:0]            k_q, k_d;
  logic [2:0]            row_q, row_d, col_q, col_d;
  logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic [1:0]            qsel_q, qsel_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [OUT_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  block_done_q, block_done_d;
  logic                  overflow_q, overflow_d;

  logic                  accept, last_beat, release_ok;
  logic [1:0]            mode_eff;
  logic [3:0]            diag;
  logic [2:0]            shift_amt;
  logic [EXT_W-1:0]      ext, shifted;
  logic [6:0]            hi;
  logic                  pos_ovf, neg_ovf;
  logic [2:0]            row_step, col_step;

  function automatic logic [2:0] shift_for(input logic [1:0] mode, input logic [3:0] d);
    logic [2:0] s;
    s = 3'd0;
    if (mode == 2'd0) begin
      if (d == 4'd0)       s = 3'd3;
      else if (d == 4'd1)  s = 3'd2;
      else if (d <= 4'd3)  s = 3'd3;
      else if (d <= 4'd5)  s = 3'd4;
      else if (d <= 4'd7)  s = 3'd5;
      else                 s = 3'd6;
    end else if (mode == 2'd1) begin
      if (d == 4'd0)       s = 3'd3;
      else if (d <= 4'd3)  s = 3'd1;
      else if (d <= 4'd5)  s = 3'd2;
      else if (d <= 4'd7)  s = 3'd3;
      else if (d <= 4'd10) s = 3'd4;
      else                 s = 3'd5;
    end
    return s;
  endfunction

  assign in_ready   = ~bank_full_q[wr_bank_q];
  assign accept     = in_valid & in_ready;
  assign last_beat  = (k_q == 6'd63);
  assign release_ok = bank_release & bank_full_q[rd_bank_q];
  assign mode_eff   = (k_q == 6'd0) ? quant_sel : qsel_q;
  assign diag       = {1'b0, row_q} + {1'b0, col_q};
  assign shift_amt  = shift_for(mode_eff, diag);

  // The extended width leaves room for the largest shift, so any clamp shows up
  // as the bits above the output sign bit disagreeing.
  assign ext     = {{(EXT_W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign shifted = ext << shift_amt;
  assign hi      = shifted[EXT_W-1:OUT_WIDTH-1];
  assign pos_ovf = ~hi[6] & (|hi);
  assign neg_ovf = hi[6] & ~(&hi);

  always_comb begin
    row_step = row_q;
    col_step = col_q;
    if (!diag[0]) begin
      if (row_q == 3'd0 && col_q != 3'd7) col_step = col_q + 3'd1;
      else if (col_q == 3'd7)             row_step = row_q + 3'd1;
      else begin
        row_step = row_q - 3'd1;
        col_step = col_q + 3'd1;
      end
    end else begin
      if (col_q == 3'd0 && row_q != 3'd7) row_step = row_q + 3'd1;
      else if (row_q == 3'd7)             col_step = col_q + 3'd1;
      else begin
        row_step = row_q + 3'd1;
        col_step = col_q - 3'd1;
      end
    end
  end

  always_comb begin
    k_d          = k_q;
    row_d        = row_q;
    col_d        = col_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_full_d  = bank_full_q;
    qsel_d       = qsel_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    block_done_d = 1'b0;
    overflow_d   = overflow_q;

    if (accept) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = BASE + ADDR_WIDTH'({wr_bank_q, row_q, col_q});
      qsel_d       = mode_eff;
      block_done_d = last_beat;
      if (pos_ovf)      wr_data_d = SAT_MAX;
      else if (neg_ovf) wr_data_d = SAT_MIN;
      else              wr_data_d = shifted[OUT_WIDTH-1:0];
      overflow_d = overflow_q | pos_ovf | neg_ovf;
      if (last_beat) begin
        k_d                    = 6'd0;
        row_d                  = 3'd0;
        col_d                  = 3'd0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end else begin
        k_d   = k_q + 6'd1;
        row_d = row_step;
        col_d = col_step;
      end
    end

    // A release only ever targets a full bank, so it never collides with the set above.
    if (release_ok) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k_q          <= 6'd0;
      row_q        <= 3'd0;
      col_q        <= 3'd0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      qsel_q       <= 2'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE;
      wr_data_q    <= '0;
      block_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      k_q          <= k_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      qsel_q       <= qsel_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      block_done_q <= block_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign block_done = block_done_q;
  assign bank_full  = bank_full_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/zigzag_dequantizer_pp.md
Name: zigzag_dequantizer_pp

Overview:
- Parametrised successor to the Milestone 3 dequantization shifter. Accepts a stream of signed quantized coefficients in JPEG zig-zag order over a valid/ready handshake.
- Each coefficient is multiplied by its quantization factor (a power of two chosen by diagonal index and quantization mode), saturated, and written to a ping-pong buffered 8x8 block RAM at its row/column address.
- Sits between the lossless-decode stage and the IDCT fetch logic; the IDCT side frees banks via a release pulse.

Parameters:
- IN_WIDTH, 9, signed input coefficient width (>=2).
- OUT_WIDTH, 16, signed output width (>=IN_WIDTH).
- ADDR_WIDTH, 8, RAM address width (>=7).
- BASE_ADDR, 0, offset added to the internal {bank,row,col} address; result truncated to ADDR_WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  coefficient present on in_data.
- in_ready  out  1  block can accept a coefficient this cycle.
- in_data  in  IN_WIDTH  signed quantized coefficient.
- quant_sel  in  2  mode: 0=Q0, 1=Q1, 2/3=bypass (shift 0).
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_WIDTH  BASE_ADDR + {bank,row[2:0],col[2:0]}.
- wr_data  out  OUT_WIDTH  dequantized coefficient.
- block_done  out  1  one-cycle pulse coincident with the 64th write of a block.
- bank_release  in  1  consumer frees the bank it is reading.
- bank_full  out  2  per-bank full flags.
- overflow  out  1  sticky: some write saturated since reset.

Behaviour:
- Reset (synchronous, highest priority, mid-block allowed): k=0, row=col=0, wr_bank=0, rd_bank=0, bank_full=00, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, block_done=0, overflow=0. A partial block is discarded.
- Handshake: accept when in_valid & in_ready. in_ready = ~bank_full[wr_bank] (combinational, not dependent on in_valid).
- Latency: 1 cycle. An accept at edge N produces registered wr_en=1, wr_addr, wr_data valid after N. With no accept, wr_en=0 and wr_addr/wr_data hold.
- quant_sel is latched on the accept with k=0 and applies to the whole block; changes mid-block are ignored.
- Shift, with d=row+col:
  - Q0: d0:3, d1:2, d2-3:3, d4-5:4, d6-7:5, d8-14:6.
  - Q1: d0:3, d1-3:1, d4-5:2, d6-7:3, d8-10:4, d11-14:5.
  - Bypass: 0.
- Arithmetic: sign-extend in_data, shift left, saturate to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Any clamp sets overflow.
- Zig-zag next position, applied on each accept (current position is used for the address/shift):
  - d even: row==0 & col<7 -> col+1; else col==7 -> row+1; else row-1, col+1.
  - d odd: col==0 & row<7 -> row+1; else row==7 -> col+1; else row+1, col-1.
- Resulting sequence: (0,0),(0,1),(1,0),(2,0),(1,1),(0,2)...(7,7).
- Counter k runs 0..63. On the accept with k=63:
  - k, row and col return to 0.
  - bank_full[wr_bank] sets on the same edge, so it is visible with the final write and block_done.
  - wr_bank toggles.
- bank_release: if bank_full[rd_bank]=1, clear it and toggle rd_bank; otherwise ignore.
- Same-cycle set and release:
  - Release of rd_bank and the full-set of wr_bank are applied independently.
  - If rd_bank==wr_bank and that bank is not yet full, the release is ignored and the set still occurs.
- Both banks full: in_ready=0 until a release.

Test Plan:
- Q0, 64 accepts of in_data=1, BASE_ADDR=0 -> addresses 0,1,8,16,9,2,3,10...63; data 8,4,4,8,8,8...64 at (7,7); block_done with addr 63; bank_full=01.
- Q1, in_data=-1 (9'h1FF) -> (0,0)=-8, (0,1)=-2, (2,2)=-4, (7,7)=-32; sign correct in 16 bits.
- OUT_WIDTH=12, Q0, in_data=255 -> (0,0)=2040 with no overflow; (7,7)=2047 (clamped from 16320) and overflow=1 stays set. in_data=-256 at d14 -> -2048.
- Back-pressure: 128 accepts without release -> in_ready=0 after the 128th, bank_full=11. One bank_release -> bank_full=10, in_ready=1, next write at addr 0 (bank 0).
- quant_sel toggled 0->1 after the first accept -> whole block uses Q0 factors. Gaps in in_valid -> no wr_en in those cycles, sequence continues.
- Reset asserted after 20 accepts -> next accepted coefficient writes addr BASE_ADDR, bank_full=00, overflow=0, and the block completes after 64 further accepts.
